// File: rtl/cva6_lsu_model_pkg.sv
// Shared types and helpers for the store-buffer LSU model.
package cva6_lsu_model_pkg;

  localparam int unsigned MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SB,
    REQ
  } load_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  committed;
    logic [MAX_ADDR_W-1:0] addr;
  } sb_entry_t;

  // Equality of a and b restricted to bit range [hi-1:lo].
  function automatic logic addr_match(input logic [MAX_ADDR_W-1:0] a,
                                      input logic [MAX_ADDR_W-1:0] b,
                                      input int unsigned hi,
                                      input int unsigned lo);
    logic m;
    m = 1'b1;
    for (int unsigned i = 0; i < MAX_ADDR_W; i++) begin
      if ((i >= lo) && (i < hi) && (a[i] != b[i])) m = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/cva6_lsu_store_buffer.sv
// In-order circular store buffer: speculative -> committed -> retired, with flush
// of speculative entries and a per-entry address match against a query address.
module cva6_lsu_store_buffer
  import cva6_lsu_model_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned CMP_HI   = 12,
  parameter int unsigned CMP_LO   = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [ADDR_W-1:0]                push_addr,
  input  logic                             commit,
  input  logic                             flush,
  input  logic                             store_resp,
  input  logic [ADDR_W-1:0]                query_addr,
  output logic                             full,
  output logic [$clog2(SB_DEPTH+1)-1:0]    count,
  output logic                             store_req,
  output logic [ADDR_W-1:0]                store_addr,
  output logic [SB_DEPTH-1:0]              match_vec
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = $clog2(SB_DEPTH + 1);

  sb_entry_t        entries_q [SB_DEPTH];
  logic [PTR_W:0]   head_q, cmt_q, tail_q;
  logic [PTR_W:0]   head_d, cmt_d, tail_d;
  logic             commit_ok, retire, push_ok;
  logic [PTR_W-1:0] head_idx, cmt_idx, tail_idx;

  assign head_idx = head_q[PTR_W-1:0];
  assign cmt_idx  = cmt_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];

  // Extra pointer MSB distinguishes full from empty.
  assign full       = (head_q[PTR_W] != tail_q[PTR_W]) && (head_idx == tail_idx);
  assign count      = CNT_W'(tail_q - head_q);
  assign store_req  = entries_q[head_idx].valid && entries_q[head_idx].committed;
  assign store_addr = ADDR_W'(entries_q[head_idx].addr);

  always_comb begin
    commit_ok = commit && (cmt_q != tail_q);
    retire    = store_resp && store_req;
    push_ok   = push && !flush && !full;
    head_d    = head_q + (PTR_W + 1)'(retire);
    cmt_d     = cmt_q + (PTR_W + 1)'(commit_ok);
    tail_d    = flush ? cmt_d : (tail_q + (PTR_W + 1)'(push_ok));
  end

  always_comb begin
    match_vec = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      match_vec[i] = entries_q[i].valid &&
                     addr_match(entries_q[i].addr, MAX_ADDR_W'(query_addr), CMP_HI, CMP_LO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

  // Commit is applied after the flush sweep so the entry committed this cycle survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      if (flush) begin
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
          if (entries_q[i].valid && !entries_q[i].committed) entries_q[i].valid <= 1'b0;
        end
      end
      if (commit_ok) begin
        entries_q[cmt_idx].valid     <= 1'b1;
        entries_q[cmt_idx].committed <= 1'b1;
      end
      if (retire) entries_q[head_idx].valid <= 1'b0;
      if (push_ok) begin
        entries_q[tail_idx] <= '{valid: 1'b1, committed: 1'b0, addr: MAX_ADDR_W'(push_addr)};
      end
    end
  end

endmodule

// File: rtl/cva6_lsu_sb_model.sv
// LSU model with an in-order store buffer and a load FSM that blocks on
// page-offset conflicts with buffered stores.
module cva6_lsu_sb_model
  import cva6_lsu_model_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned CMP_HI   = 12,
  parameter int unsigned CMP_LO   = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [ADDR_W-1:0]             instr_i,
  input  logic                          is_load_i,
  input  logic                          instr_valid_i,
  input  logic                          store_commit_i,
  input  logic                          flush_i,
  input  logic                          store_mem_resp_i,
  input  logic                          load_mem_resp_i,
  output logic                          ready_o,
  output logic                          load_req_o,
  output logic [ADDR_W-1:0]             load_addr_o,
  output logic                          store_req_o,
  output logic [ADDR_W-1:0]             store_addr_o,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count_o
);

  load_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    load_addr_q, load_addr_d;
  logic                 sb_full;
  logic                 accept, store_push, load_accept, conflict;
  logic [ADDR_W-1:0]    query_addr;
  logic [SB_DEPTH-1:0]  match_vec;

  assign ready_o     = (state_q == IDLE) && !sb_full;
  assign load_req_o  = (state_q == REQ);
  assign load_addr_o = load_addr_q;

  assign accept      = instr_valid_i && ready_o;
  assign store_push  = accept && !is_load_i;
  assign load_accept = accept && is_load_i;

  // New loads are checked on the incoming address, blocked loads on the captured one.
  assign query_addr  = (state_q == IDLE) ? instr_i : load_addr_q;
  assign conflict    = |match_vec;

  cva6_lsu_store_buffer #(
    .ADDR_W  (ADDR_W),
    .SB_DEPTH(SB_DEPTH),
    .CMP_HI  (CMP_HI),
    .CMP_LO  (CMP_LO)
  ) i_sb (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (store_push),
    .push_addr (instr_i),
    .commit    (store_commit_i),
    .flush     (flush_i),
    .store_resp(store_mem_resp_i),
    .query_addr(query_addr),
    .full      (sb_full),
    .count     (sb_count_o),
    .store_req (store_req_o),
    .store_addr(store_addr_o),
    .match_vec (match_vec)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      load_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    case (state_q)
      IDLE: begin
        if (load_accept) begin
          load_addr_d = instr_i;
          state_d     = conflict ? WAIT_SB : REQ;
        end
      end
      WAIT_SB: begin
        if (flush_i)        state_d = IDLE;
        else if (!conflict) state_d = REQ;
      end
      REQ: begin
        // Already at memory, so flush cannot abort it.
        if (load_mem_resp_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cva6_lsu_sb_model.sv
// Scoreboard bench for cva6_lsu_sb_model: directed stimulus, memory responders
// that pop expected addresses whenever a request is acknowledged.
module tb_cva6_lsu_sb_model;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] instr_i;
  logic        is_load_i;
  logic        instr_valid_i;
  logic        store_commit_i;
  logic        flush_i;
  logic        store_mem_resp_i;
  logic        load_mem_resp_i;
  logic        ready_o;
  logic        load_req_o;
  logic [31:0] load_addr_o;
  logic        store_req_o;
  logic [31:0] store_addr_o;
  logic [2:0]  sb_count_o;

  int checks = 0;
  int errors = 0;
  logic store_resp_en = 1'b0;
  logic load_resp_en  = 1'b0;
  logic [31:0] exp_store_q[$];
  logic [31:0] exp_load_q[$];

  cva6_lsu_sb_model dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .instr_i         (instr_i),
    .is_load_i       (is_load_i),
    .instr_valid_i   (instr_valid_i),
    .store_commit_i  (store_commit_i),
    .flush_i         (flush_i),
    .store_mem_resp_i(store_mem_resp_i),
    .load_mem_resp_i (load_mem_resp_i),
    .ready_o         (ready_o),
    .load_req_o      (load_req_o),
    .load_addr_o     (load_addr_o),
    .store_req_o     (store_req_o),
    .store_addr_o    (store_addr_o),
    .sb_count_o      (sb_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Store memory stub: acks every request when enabled and checks drain order.
  initial begin
    store_mem_resp_i = 1'b0;
    forever begin
      @(negedge clk_i);
      #1;
      store_mem_resp_i = store_resp_en && store_req_o;
      if (store_mem_resp_i) begin
        if (exp_store_q.size() == 0) chk("store_unexpected_req", {32'd0, store_addr_o}, 64'hdead);
        else chk("store_drain_addr", {32'd0, store_addr_o}, {32'd0, exp_store_q.pop_front()});
      end
    end
  end

  // Load memory stub.
  initial begin
    load_mem_resp_i = 1'b0;
    forever begin
      @(negedge clk_i);
      #1;
      load_mem_resp_i = load_resp_en && load_req_o;
      if (load_mem_resp_i) begin
        if (exp_load_q.size() == 0) chk("load_unexpected_req", {32'd0, load_addr_o}, 64'hdead);
        else chk("load_req_addr", {32'd0, load_addr_o}, {32'd0, exp_load_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(negedge clk_i);
    instr_valid_i  = 1'b0;
    store_commit_i = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic st(input logic [31:0] a);
    instr_valid_i = 1'b1; is_load_i = 1'b0; instr_i = a;
    cycle();
  endtask

  task automatic ld(input logic [31:0] a);
    instr_valid_i = 1'b1; is_load_i = 1'b1; instr_i = a;
    cycle();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_count_o != 3'd0 && n < 20) begin
      cycle();
      n++;
    end
    chk(name, 64'(sb_count_o), 64'd0);
  endtask

  initial begin
    rst_ni = 1'b0; instr_i = '0; is_load_i = 1'b0; instr_valid_i = 1'b0;
    store_commit_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_load_req", 64'(load_req_o), 64'd0);
    chk("rst_store_req", 64'(store_req_o), 64'd0);
    chk("rst_store_addr", 64'(store_addr_o), 64'd0);
    chk("rst_count", 64'(sb_count_o), 64'd0);
    chk("rst_load_addr", 64'(load_addr_o), 64'd0);
    rst_ni = 1'b1;
    cycle();

    // 1: single store, commit two cycles later, drains on first request
    store_resp_en = 1'b1;
    exp_store_q.push_back(32'hcad);
    st(32'hcad);
    chk("t1_count_accept", 64'(sb_count_o), 64'd1);
    chk("t1_no_req_spec", 64'(store_req_o), 64'd0);
    cycle();
    chk("t1_no_req_t1", 64'(store_req_o), 64'd0);
    store_commit_i = 1'b1;
    cycle();
    chk("t1_req_t3", 64'(store_req_o), 64'd1);
    chk("t1_addr_t3", 64'(store_addr_o), 64'hcad);
    chk("t1_count_before_retire", 64'(sb_count_o), 64'd1);
    cycle();
    chk("t1_count_retired", 64'(sb_count_o), 64'd0);
    chk("t1_req_drop", 64'(store_req_o), 64'd0);

    // 2: load with empty SB goes straight to memory
    load_resp_en = 1'b1;
    exp_load_q.push_back(32'h100);
    ld(32'h100);
    chk("t2_load_req", 64'(load_req_o), 64'd1);
    chk("t2_load_addr", 64'(load_addr_o), 64'h100);
    chk("t2_not_ready", 64'(ready_o), 64'd0);
    cycle();
    chk("t2_ready_after_resp", 64'(ready_o), 64'd1);
    chk("t2_load_req_low", 64'(load_req_o), 64'd0);

    // 3: load blocked by an uncommitted store on the same page offset
    st(32'hcad);
    ld(32'h1cad);
    chk("t3_blocked_no_req", 64'(load_req_o), 64'd0);
    chk("t3_blocked_not_ready", 64'(ready_o), 64'd0);
    cycle();
    cycle();
    chk("t3_still_blocked", 64'(load_req_o), 64'd0);
    exp_store_q.push_back(32'hcad);
    exp_load_q.push_back(32'h1cad);
    store_commit_i = 1'b1;
    cycle();
    chk("t3_store_req", 64'(store_req_o), 64'd1);
    chk("t3_blocked_at_commit", 64'(load_req_o), 64'd0);
    cycle();
    chk("t3_count_retired", 64'(sb_count_o), 64'd0);
    chk("t3_blocked_retire_cycle", 64'(load_req_o), 64'd0);
    cycle();
    chk("t3_load_req", 64'(load_req_o), 64'd1);
    chk("t3_load_addr", 64'(load_addr_o), 64'h1cad);
    cycle();
    chk("t3_ready", 64'(ready_o), 64'd1);

    // 4: fill, commit two (second together with flush), drain committed ones
    store_resp_en = 1'b0;
    st(32'h1000); st(32'h2008); st(32'h3010); st(32'h4018);
    chk("t4_full_not_ready", 64'(ready_o), 64'd0);
    chk("t4_full_count", 64'(sb_count_o), 64'd4);
    store_commit_i = 1'b1;
    cycle();
    store_commit_i = 1'b1; flush_i = 1'b1;
    cycle();
    chk("t4_count_after_flush", 64'(sb_count_o), 64'd2);
    chk("t4_ready_after_flush", 64'(ready_o), 64'd1);
    chk("t4_head_addr", 64'(store_addr_o), 64'h1000);
    exp_store_q.push_back(32'h1000);
    exp_store_q.push_back(32'h2008);
    store_resp_en = 1'b1;
    wait_drain("t4_drained");
    cycle();

    // 4b: store in flush cycle dropped; commit alongside first accept ignored
    instr_valid_i = 1'b1; is_load_i = 1'b0; instr_i = 32'h7000; flush_i = 1'b1;
    cycle();
    chk("t4b_flush_drops_store", 64'(sb_count_o), 64'd0);
    instr_valid_i = 1'b1; is_load_i = 1'b0; instr_i = 32'h7008; store_commit_i = 1'b1;
    cycle();
    chk("t4b_count_accept", 64'(sb_count_o), 64'd1);
    cycle();
    chk("t4b_commit_ignored", 64'(store_req_o), 64'd0);
    flush_i = 1'b1;
    cycle();
    chk("t4b_flushed", 64'(sb_count_o), 64'd0);

    // 5: flush a blocked load, then flush while a load is at memory
    st(32'h2a8);
    ld(32'h82a8);
    chk("t5_blocked", 64'(ready_o), 64'd0);
    flush_i = 1'b1;
    cycle();
    chk("t5_idle_after_flush", 64'(ready_o), 64'd1);
    chk("t5_count_flushed", 64'(sb_count_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_load_req", 64'(load_req_o), 64'd0);
      cycle();
    end
    load_resp_en = 1'b0;
    ld(32'h300);
    chk("t5_req_up", 64'(load_req_o), 64'd1);
    flush_i = 1'b1;
    cycle();
    chk("t5_req_survives_flush", 64'(load_req_o), 64'd1);
    chk("t5_req_addr", 64'(load_addr_o), 64'h300);
    cycle();
    chk("t5_req_held", 64'(load_req_o), 64'd1);
    exp_load_q.push_back(32'h300);
    load_resp_en = 1'b1;
    cycle();
    chk("t5_req_done", 64'(load_req_o), 64'd0);
    chk("t5_ready_done", 64'(ready_o), 64'd1);

    // 6: asynchronous reset in the middle of a drain
    store_resp_en = 1'b0;
    st(32'ha00); st(32'hb00); st(32'hc00);
    store_commit_i = 1'b1; cycle();
    store_commit_i = 1'b1; cycle();
    store_commit_i = 1'b1; cycle();
    chk("t6_count3", 64'(sb_count_o), 64'd3);
    exp_store_q.push_back(32'ha00);
    store_resp_en = 1'b1;
    cycle();
    store_resp_en = 1'b0;
    chk("t6_count2", 64'(sb_count_o), 64'd2);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_rst_ready", 64'(ready_o), 64'd1);
    chk("t6_rst_load_req", 64'(load_req_o), 64'd0);
    chk("t6_rst_store_req", 64'(store_req_o), 64'd0);
    chk("t6_rst_store_addr", 64'(store_addr_o), 64'd0);
    chk("t6_rst_count", 64'(sb_count_o), 64'd0);
    chk("t6_rst_load_addr", 64'(load_addr_o), 64'd0);
    cycle();
    rst_ni = 1'b1;
    cycle();
    st(32'hd00);
    chk("t6_new_count", 64'(sb_count_o), 64'd1);
    exp_store_q.push_back(32'hd00);
    store_resp_en = 1'b1;
    store_commit_i = 1'b1;
    cycle();
    chk("t6_new_req", 64'(store_req_o), 64'd1);
    chk("t6_new_addr", 64'(store_addr_o), 64'hd00);
    wait_drain("t6_drained");
    cycle();

    chk("sb_store_queue_empty", 64'(exp_store_q.size()), 64'd0);
    chk("sb_load_queue_empty", 64'(exp_load_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
